// File: rtl/nasti_stream_writer_if.sv
// NASTI bus bundles used by the stream writer: an AXI-stream style data
// channel and the write/read control side of a NASTI memory port.

interface nasti_stream_channel #(
   parameter int DATA_WIDTH = 64
);
   logic                  t_valid;
   logic                  t_ready;
   logic [DATA_WIDTH-1:0] t_data;
   logic                  t_last;

   modport master (output t_valid, t_data, t_last, input t_ready);
   modport slave  (input t_valid, t_data, t_last, output t_ready);
endinterface

interface nasti_channel #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
);
   // write address
   logic [3:0]              aw_id;
   logic [ADDR_WIDTH-1:0]   aw_addr;
   logic [7:0]              aw_len;
   logic [2:0]              aw_size;
   logic [1:0]              aw_burst;
   logic                    aw_lock;
   logic [3:0]              aw_cache;
   logic [2:0]              aw_prot;
   logic                    aw_valid;
   logic                    aw_ready;
   // write data
   logic [DATA_WIDTH-1:0]   w_data;
   logic [DATA_WIDTH/8-1:0] w_strb;
   logic                    w_last;
   logic                    w_user;
   logic                    w_valid;
   logic                    w_ready;
   // write response
   logic [1:0]              b_resp;
   logic                    b_valid;
   logic                    b_ready;
   // read side handshakes (held idle by a write-only master)
   logic                    ar_valid;
   logic                    r_ready;

   modport master (
      output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_valid,
      output w_data, w_strb, w_last, w_user, w_valid, b_ready, ar_valid, r_ready,
      input  aw_ready, w_ready, b_resp, b_valid
   );
   modport slave (
      input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_valid,
      input  w_data, w_strb, w_last, w_user, w_valid, b_ready, ar_valid, r_ready,
      output aw_ready, w_ready, b_resp, b_valid
   );
endinterface

// File: rtl/nasti_stream_writer.sv
// Stream-to-memory write engine: drains len bytes from a stream and writes
// them to dest as INCR bursts, one burst outstanding at a time.

module nasti_stream_writer #(
   parameter int ADDR_WIDTH       = 64,
   parameter int DATA_WIDTH       = 64,
   parameter int MAX_BURST_LENGTH = 8
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   nasti_stream_channel.slave    src,
   nasti_channel.master          dest,
   input  logic [ADDR_WIDTH-1:0] w_dest,
   input  logic [ADDR_WIDTH-1:0] w_len,
   input  logic                  w_valid,
   output logic                  w_ready,
   output logic                  w_err
);
   localparam int DATA_BYTE_CNT = DATA_WIDTH / 8;
   localparam int ADDR_SHIFT    = $clog2(DATA_BYTE_CNT);
   localparam int CNT_W         = $clog2(MAX_BURST_LENGTH) + 1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'(DATA_BYTE_CNT - 1);
   localparam logic [ADDR_WIDTH-1:0] MAX_BEATS = ADDR_WIDTH'(MAX_BURST_LENGTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] len_q, len_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  err_q, err_d;

   logic [ADDR_WIDTH-1:0] len_beats;
   logic [CNT_W-1:0]      beats;
   logic [ADDR_WIDTH-1:0] burst_bytes;
   logic                  in_data;
   logic                  w_hs;
   logic                  unused_t_last;

   // Burst size is clamped at full length width so huge lengths never wrap.
   assign len_beats   = len_q >> ADDR_SHIFT;
   assign beats       = (len_beats > MAX_BEATS) ? CNT_W'(MAX_BURST_LENGTH) : CNT_W'(len_beats);
   assign burst_bytes = ADDR_WIDTH'(beats) << ADDR_SHIFT;
   assign in_data     = (state_q == S_DATA);
   assign w_hs        = in_data && src.t_valid && dest.w_ready;

   // Stream framing comes from the request length only; t_last is ignored.
   assign unused_t_last = src.t_last;

   assign w_ready = (state_q == S_IDLE);
   assign w_err   = err_q;

   assign dest.aw_id    = '0;
   assign dest.aw_addr  = addr_q;
   assign dest.aw_len   = 8'(beats - CNT_W'(1));
   assign dest.aw_size  = 3'(ADDR_SHIFT);
   assign dest.aw_burst = 2'b01;
   assign dest.aw_lock  = 1'b0;
   assign dest.aw_cache = '0;
   assign dest.aw_prot  = '0;
   // A zero-length request parks in ADDR for one cycle without issuing AW.
   assign dest.aw_valid = (state_q == S_ADDR) && (len_q != '0);

   // W is a straight pass-through of the stream while a burst is open.
   assign dest.w_data   = src.t_data;
   assign dest.w_strb   = '1;
   assign dest.w_user   = 1'b0;
   assign dest.w_valid  = in_data && src.t_valid;
   assign dest.w_last   = in_data && (cnt_q == CNT_W'(1));
   assign src.t_ready   = in_data && dest.w_ready;

   assign dest.b_ready  = (state_q == S_RESP);
   assign dest.ar_valid = 1'b0;
   assign dest.r_ready  = 1'b0;

   // Next-state logic: request latch, burst issue, beat count, response.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: if (w_valid) begin
            addr_d  = w_dest & ~ADDR_MASK;
            len_d   = w_len & ~ADDR_MASK;
            err_d   = 1'b0;
            state_d = S_ADDR;
         end
         S_ADDR: begin
            if (len_q == '0) begin
               state_d = S_IDLE;
            end else if (dest.aw_ready) begin
               cnt_d   = beats;
               addr_d  = addr_q + burst_bytes;
               len_d   = len_q - burst_bytes;
               state_d = S_DATA;
            end
         end
         S_DATA: if (w_hs) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = S_RESP;
         end
         S_RESP: if (dest.b_valid) begin
            if (dest.b_resp != 2'b00) err_d = 1'b1;
            state_d = (len_q == '0) ? S_IDLE : S_ADDR;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset abandons any request in flight.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Requests must be beat aligned; low bits are dropped in hardware.
   assert property (@(posedge aclk) disable iff (!aresetn)
      (w_valid && w_ready) |-> (((w_dest | w_len) & ADDR_MASK) == '0));

endmodule

// File: tb/tb_nasti_stream_writer.sv
// Bench for nasti_stream_writer: random stream source and memory slave,
// expected bursts/data/error computed from each request's address and length.

module tb_nasti_stream_writer;
   localparam int AW  = 64;
   localparam int DW  = 64;
   localparam int MBL = 8;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic [AW-1:0] w_dest = '0;
   logic [AW-1:0] w_len = '0;
   logic          w_valid = 1'b0;
   logic          w_ready, w_err;

   always #5 aclk = ~aclk;

   nasti_stream_channel #(.DATA_WIDTH(DW)) src ();
   nasti_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dest ();

   nasti_stream_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST_LENGTH(MBL)) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .src     (src),
      .dest    (dest),
      .w_dest  (w_dest),
      .w_len   (w_len),
      .w_valid (w_valid),
      .w_ready (w_ready),
      .w_err   (w_err)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // slave / source state
   logic [63:0] sq[$];
   logic [1:0]  bresp_q[$];
   logic [63:0] mem [logic [63:0]];
   logic [71:0] aw_log[$];
   int tv_pct = 100, awr_pct = 100, wr_pct = 100;
   int beats_left = 0, outstanding = 0, consumed = 0, viol = 0;
   int cyc = 0, b_commit_cyc = 0, b_dly = 0;
   bit b_pend = 0;
   logic [63:0] cur_addr = '0;
   bit hs_aw = 0, hs_w = 0, hs_t = 0, hs_b = 0;
   logic [63:0] s_awaddr, s_wdata;
   logic [7:0]  s_awlen;
   logic        s_wlast;

   // Stream source + memory slave: commits last cycle's handshakes, drives
   // new random values, then samples handshakes and protocol invariants.
   initial begin : slave
      src.t_valid = 0; src.t_data = '0; src.t_last = 0;
      dest.aw_ready = 0; dest.w_ready = 0; dest.b_valid = 0; dest.b_resp = 2'b00;
      forever begin
         @(negedge aclk);
         cyc++;
         if (!aresetn) begin
            hs_aw = 0; hs_w = 0; hs_t = 0; hs_b = 0;
            beats_left = 0; outstanding = 0; b_pend = 0;
            src.t_valid = 0; dest.b_valid = 0;
            continue;
         end
         if (hs_aw) begin
            aw_log.push_back({s_awaddr, s_awlen});
            if (outstanding != 0) viol++;
            outstanding++;
            beats_left = int'(s_awlen) + 1;
            cur_addr = s_awaddr;
         end
         if (hs_w) begin
            if (beats_left == 0) viol++;
            else begin
               mem[cur_addr] = s_wdata;
               cur_addr += 8;
               beats_left--;
               if (s_wlast != (beats_left == 0)) viol++;
               if (beats_left == 0) begin
                  b_pend = 1;
                  b_dly = $urandom_range(0, 2);
               end
            end
         end
         if (hs_t) begin
            consumed++;
            if (sq.size() > 0) void'(sq.pop_front());
            src.t_valid = 0;
         end
         if (hs_b) begin
            b_pend = 0; dest.b_valid = 0; outstanding--; b_commit_cyc = cyc;
         end
         if (!src.t_valid && sq.size() > 0 && $urandom_range(0, 99) < tv_pct) src.t_valid = 1;
         if (sq.size() == 0) src.t_valid = 0;
         src.t_data = (sq.size() > 0) ? sq[0] : '0;
         src.t_last = 1'($urandom_range(0, 1));
         dest.aw_ready = ($urandom_range(0, 99) < awr_pct);
         dest.w_ready  = ($urandom_range(0, 99) < wr_pct);
         if (b_pend && !dest.b_valid) begin
            if (b_dly > 0) b_dly--;
            else begin
               dest.b_valid = 1;
               if (bresp_q.size() > 0) dest.b_resp = bresp_q.pop_front();
               else dest.b_resp = 2'b00;
            end
         end
         #1;
         hs_aw = dest.aw_valid && dest.aw_ready; s_awaddr = dest.aw_addr; s_awlen = dest.aw_len;
         hs_w  = dest.w_valid && dest.w_ready;   s_wdata = dest.w_data;   s_wlast = dest.w_last;
         hs_t  = src.t_valid && src.t_ready;
         hs_b  = dest.b_valid && dest.b_ready;
         if ((src.t_ready || dest.w_valid) && beats_left == 0) viol++;
         if (dest.b_ready !== (outstanding > 0 && beats_left == 0)) viol++;
         if (dest.aw_valid && outstanding != 0) viol++;
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge aclk);
   endtask

   // Issue one request and compare against the expected burst split,
   // memory image, stream consumption and error flag.
   task automatic run_req(input logic [63:0] d, input logic [63:0] l, input string tag);
      logic [63:0] exp_data[$];
      logic [71:0] exp_aw[$];
      logic [63:0] off, bl, a;
      logic        exp_err;
      int n, cycles;
      bit done;
      n = int'(l >> 3);
      sq.delete(); mem.delete(); aw_log.delete(); consumed = 0; viol = 0;
      for (int i = 0; i < n + 3; i++) begin
         a = {$urandom, $urandom};
         if (i < n) exp_data.push_back(a);
         sq.push_back(a);
      end
      off = '0;
      while (off < l) begin
         bl = ((l - off) >> 3 > MBL) ? 64'(MBL) : (l - off) >> 3;
         exp_aw.push_back({d + off, 8'(bl - 1)});
         off += bl << 3;
      end
      exp_err = 0;
      for (int i = 0; i < exp_aw.size(); i++)
         if (i < bresp_q.size() && bresp_q[i] != 2'b00) exp_err = 1;

      @(negedge aclk); w_dest = d; w_len = l; w_valid = 1;
      #2; chk({tag, ":ready_idle"}, 80'(w_ready), 80'(1));
      @(negedge aclk); w_valid = 0;
      #2; chk({tag, ":accept"}, 80'({w_ready, w_err, dest.aw_valid}), 80'({1'b0, 1'b0, (l != 0)}));
      cycles = 0; done = 0;
      while (!done && cycles < 3000) begin
         @(negedge aclk); #2; cycles++;
         if (w_ready) done = 1;
      end
      chk({tag, ":done"}, 80'(done), 80'(1));
      if (l == 0) chk({tag, ":zero_gap"}, 80'(cycles), 80'(1));
      else chk({tag, ":ready_after_b"}, 80'(cyc), 80'(b_commit_cyc));
      chk({tag, ":w_err"}, 80'(w_err), 80'(exp_err));
      chk({tag, ":aw_count"}, 80'(aw_log.size()), 80'(exp_aw.size()));
      for (int i = 0; i < exp_aw.size(); i++)
         chk({tag, ":aw"}, (i < aw_log.size()) ? 80'(aw_log[i]) : 80'hx, 80'(exp_aw[i]));
      for (int i = 0; i < n; i++) begin
         a = d + 64'(i * 8);
         chk({tag, ":data"}, mem.exists(a) ? 80'(mem[a]) : 80'hx, 80'(exp_data[i]));
      end
      chk({tag, ":beats"}, 80'(consumed), 80'(n));
      chk({tag, ":protocol"}, 80'(viol), 80'(0));
      bresp_q.delete();
   endtask

   initial begin : main
      int c;
      logic [63:0] d, l;
      wait_cyc(3); #2;
      chk("reset", 80'({w_ready, w_err, dest.aw_valid, dest.w_valid, dest.b_ready, src.t_ready}), 80'(6'b100000));
      chk("tieoff", 80'({dest.aw_id, dest.aw_size, dest.aw_burst, dest.aw_lock, dest.aw_cache,
                         dest.aw_prot, dest.w_strb, dest.w_user, dest.ar_valid, dest.r_ready}),
                    80'({4'h0, 3'd3, 2'b01, 1'b0, 4'h0, 3'h0, 8'hFF, 1'b0, 1'b0, 1'b0}));
      @(negedge aclk); #3 aresetn = 1;

      run_req(64'h1000, 64'h40, "single");
      run_req(64'h2000, 64'h58, "split");
      run_req(64'h3000, 64'h0, "zero");

      tv_pct = 60; awr_pct = 50; wr_pct = 60;
      for (int k = 0; k < 3; k++) begin
         d = 64'($urandom_range(1, 255)) << 12;
         l = 64'(8 * $urandom_range(1, 30));
         run_req(d, l, "random");
      end

      bresp_q.push_back(2'b10); bresp_q.push_back(2'b00);
      run_req(64'h5000, 64'h58, "slverr");
      run_req(64'h6000, 64'h10, "clear");

      // reset in the middle of a data phase
      tv_pct = 100; wr_pct = 30;
      sq.delete(); consumed = 0;
      for (int i = 0; i < 16; i++) sq.push_back({$urandom, $urandom});
      @(negedge aclk); w_dest = 64'h7000; w_len = 64'h80; w_valid = 1;
      @(negedge aclk); w_valid = 0;
      c = 0;
      while (consumed < 3 && c < 500) begin @(negedge aclk); c++; end
      chk("rst:reached_data", 80'(consumed >= 3), 80'(1));
      #3 aresetn = 0;
      #1 chk("rst:async", 80'({w_ready, w_err, dest.aw_valid, dest.w_valid, dest.b_ready, src.t_ready}), 80'(6'b100000));
      wait_cyc(2);
      sq.delete(); bresp_q.delete();
      #3 aresetn = 1;
      wr_pct = 70;
      run_req(64'h8000, 64'h48, "after_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/nasti_stream_writer.md
# nasti_stream_writer

Stream-to-memory write engine: accepts a (destination address, byte length) request, drains exactly that many bytes from an incoming NASTI-stream and writes them to memory as a sequence of INCR write bursts on a NASTI master port. It is the downstream counterpart of the stream mover: mover output streams (after any processing) terminate here and land back in memory. One request is in flight at a time. The next burst starts only after the previous write response.

## Interface
- ADDR_WIDTH, 64, address and length width
- DATA_WIDTH, 64, data width of stream and memory port. DATA_BYTE_CNT = DATA_WIDTH/8, ADDR_SHIFT = log2(DATA_BYTE_CNT)
- MAX_BURST_LENGTH, 8, maximum beats per write burst (1..256)

- aclk  input  1  clock; all state updates on rising edge
- aresetn  input  1  asynchronous active-low reset
- src  nasti_stream_channel.slave  DATA_WIDTH  incoming data stream (t_valid/t_ready/t_data used)
- dest  nasti_channel (write side used)  ADDR_WIDTH/DATA_WIDTH  memory master port: aw, w, b
- w_dest  input  ADDR_WIDTH  destination byte address
- w_len  input  ADDR_WIDTH  transfer length in bytes
- w_valid  input  1  request valid
- w_ready  output  1  idle and ready for a request
- w_err  output  1  sticky: a write response of non-OKAY was seen during the current/last request

## Operation
- Constant tie-offs: aw_id=0, aw_size=ADDR_SHIFT, aw_burst=INCR (2'b01), aw_cache=0, aw_prot=0, aw_lock=0, w_strb=all ones, w_user=0. Read side is unused: ar_valid=0, r_ready=0.
- Request: accepted when w_valid && w_ready. Latch addr = w_dest with low ADDR_SHIFT bits cleared and len = w_len with low ADDR_SHIFT bits cleared. Simulation assertion fires if either input is unaligned. Clear w_err. Drop w_ready.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE: w_ready=1. On accept, go to ADDR. If the latched len is 0, go to IDLE instead and re-raise w_ready on the next cycle. No bus activity for a zero-length request.
- ADDR: compute the burst size. beats = min(len>>ADDR_SHIFT, MAX_BURST_LENGTH). Drive aw_addr=addr, aw_len=beats-1 and aw_valid=1. On aw_ready: go to DATA; load beat counter cnt=beats; addr += beats<<ADDR_SHIFT; len -= beats<<ADDR_SHIFT.
- DATA: pass-through.
  - dest.w_valid = src.t_valid
  - dest.w_data = src.t_data
  - src.t_ready = dest.w_ready
  - dest.w_last = (cnt==1)
  - Each beat with w_valid && w_ready decrements cnt. The beat with cnt==1 moves the FSM to RESP.
- Outside DATA: w_valid=0 and t_ready=0. The stream is back-pressured.
- RESP: b_ready=1. On b_valid:
  - if b_resp != 0, set w_err
  - if len==0, go to IDLE (w_ready=1 next cycle)
  - else go to ADDR
- Stream t_last, t_strb, t_keep, t_id, t_dest and t_user are ignored. Framing is governed solely by len.
- Bursts are not split at 4 KiB boundaries. The requester guarantees that no burst crosses one.
- Widths: len and addr are ADDR_WIDTH bits. cnt is $clog2(MAX_BURST_LENGTH)+1 bits. The comparison len>>ADDR_SHIFT vs MAX_BURST_LENGTH is done at full len width (no truncation).

## Timing
- Reset values: w_ready=1, w_err=0, aw_valid=0, w_valid=0, b_ready=0, src.t_ready=0, state=IDLE. Reset mid-transfer abandons the request immediately. No recovery of a partially written burst.
- Request accept at cycle 0 puts aw_valid high at cycle 1.
- aw_valid holds with stable aw_addr/aw_len until aw_ready.
- The first W beat can be transferred the cycle after the AW handshake.
- W and stream are combinationally coupled. There is zero added latency per beat, and full throughput when both sides are ready.
- b_ready rises the cycle after the w_last handshake.
- After a B handshake, the next aw_valid is asserted the following cycle, or w_ready rises the following cycle.
- w_err is updated in the cycle after the failing B handshake. It remains set until the next request is accepted.
- w_valid ignored while w_ready=0.

## Test plan
- Request w_dest=0x1000, w_len=0x40, DATA_WIDTH=64, stream always valid, slave always ready -> one AW (addr 0x1000, len 7); 8 W beats with w_last on the 8th; b_ready after; w_ready back 1 cycle after B.
- w_len=0x58 (11 beats), MAX_BURST_LENGTH=8 -> bursts of AW(0x2000, len 7) and AW(0x2040, len 2), with the second AW issued only after the first B; exactly 11 stream beats consumed.
- w_len=0 -> no aw_valid; w_ready low for exactly 1 cycle.
- Random t_valid and w_ready gaps over 3 requests -> data order preserved; beat count exact; t_ready never high outside DATA; t_last is ignored (including when asserted early).
- First burst gets b_resp=SLVERR, second OKAY -> w_err=1 at the end of the request; the next request accept clears it to 0.
- Assert aresetn low mid-DATA -> all outputs at their reset values asynchronously; the next request completes normally.
